// File: rtl/fridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fridge_pkg
// Description : Shared types and helpers for the compartment controller bank:
//               register field encoding, per-channel compressor FSM states,
//               and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fridge_pkg;

    // Width of the register field selector on the write/read ports.
    localparam int c_FIELD_W = 2;

    typedef enum logic [1:0] {
        FIELD_SP   = 2'd0,  // temperature setpoint
        FIELD_CAP  = 2'd1,  // capacity value (clamped on write)
        FIELD_PWR  = 2'd2,  // channel power, bit 0 only
        FIELD_RSVD = 2'd3   // reserved: writes flag an error, reads return 0
    } field_e;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_COOL    = 2'd2,
        ST_LOCKOUT = 2'd3
    } fsm_state_e;

    // Bits needed to index n items, never less than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fridge_comp_fsm.sv
`default_nettype none
// ============================================================================
// Module      : fridge_comp_fsm
// Description : One compartment's compressor controller. Cuts in when the
//               sensed temperature exceeds setpoint+HYST, cuts out at or
//               below setpoint, then enforces a minimum-off lockout.
// Ports       : clk, rst_n      - clock, async active-low reset
//               pwr, ch_pwr     - appliance and channel power enables
//               temp, setpoint  - sensed temperature and target
//               comp_on         - registered compressor enable
// Revision    : 1.0 - initial release
// ============================================================================
module fridge_comp_fsm
    import fridge_pkg::*;
#(
    parameter int VAL_W   = 5,
    parameter int HYST    = 2,
    parameter int MIN_OFF = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr,
    input  logic             ch_pwr,
    input  logic [VAL_W-1:0] temp,
    input  logic [VAL_W-1:0] setpoint,
    output logic             comp_on
);

    // MIN_OFF-1 is the largest counter value, so clog2(MIN_OFF) bits suffice.
    localparam int                 c_CNT_W = ch_idx_w(MIN_OFF);
    localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(MIN_OFF - 1);
    localparam logic [VAL_W:0]     c_HYST  = (VAL_W + 1)'(HYST);

    fsm_state_e         r_state;
    fsm_state_e         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_comp_on;
    logic               w_comp_on_nxt;

    // Cut-in threshold is formed one bit wider so a high setpoint cannot wrap.
    logic [VAL_W:0] w_cut_in_lvl;
    logic           w_above_cut_in;
    logic           w_at_or_below_sp;

    assign w_cut_in_lvl     = {1'b0, setpoint} + c_HYST;
    assign w_above_cut_in   = {1'b0, temp} > w_cut_in_lvl;
    assign w_at_or_below_sp = temp <= setpoint;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_comp_on <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_comp_on <= w_comp_on_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        if (!pwr || !ch_pwr) begin
            w_next    = ST_OFF;
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_next = ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_above_cut_in) begin
                        w_next = ST_COOL;
                    end
                end
                ST_COOL: begin
                    if (w_at_or_below_sp) begin
                        w_next    = ST_LOCKOUT;
                        w_cnt_nxt = c_LOAD;
                    end
                end
                ST_LOCKOUT: begin
                    // Temperature is deliberately ignored until the count ends.
                    if (r_cnt == '0) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_next    = ST_OFF;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output logic: decoded from the next state and registered, so comp_on
    // tracks COOL exactly without a decode glitch on the output pin.
    always_comb begin
        w_comp_on_nxt = (w_next == ST_COOL);
    end

    assign comp_on = r_comp_on;

endmodule
`default_nettype wire

// File: rtl/fridge_ctrl_bank.sv
`default_nettype none
// ============================================================================
// Module      : fridge_ctrl_bank
// Description : Bank of N_CH refrigeration compartment controllers with a
//               small register file (setpoint, capacity, channel power),
//               valid/ready write port and registered read port.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               pwr                        - appliance master power
//               wr_valid/wr_ready          - write handshake
//               wr_field/wr_ch/wr_data     - write address and value
//               wr_err                     - pulse on accepted illegal write
//               rd_field/rd_ch/rd_data     - read address, registered data
//               temp_sense                 - packed per-channel temperatures
//               comp_on                    - per-channel compressor enables
// Revision    : 1.0 - initial release
// ============================================================================
module fridge_ctrl_bank
    import fridge_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int VAL_W   = 5,
    parameter int HYST    = 2,
    parameter int MIN_OFF = 16,
    parameter int CAP_MAX = 20,
    parameter int SP_RST  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pwr,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [c_FIELD_W-1:0]        wr_field,
    input  logic [ch_idx_w(N_CH)-1:0]   wr_ch,
    input  logic [VAL_W-1:0]            wr_data,
    output logic                        wr_err,
    input  logic [c_FIELD_W-1:0]        rd_field,
    input  logic [ch_idx_w(N_CH)-1:0]   rd_ch,
    output logic [VAL_W-1:0]            rd_data,
    input  logic [N_CH*VAL_W-1:0]       temp_sense,
    output logic [N_CH-1:0]             comp_on
);

    localparam int                 c_CH_W    = ch_idx_w(N_CH);
    localparam logic [c_CH_W:0]    c_N_CH    = (c_CH_W + 1)'(N_CH);
    localparam logic [VAL_W-1:0]   c_CAP_MAX = VAL_W'(CAP_MAX);
    localparam logic [VAL_W-1:0]   c_SP_RST  = VAL_W'(SP_RST);

    logic [VAL_W-1:0] r_sp  [N_CH];
    logic [VAL_W-1:0] r_cap [N_CH];
    logic [N_CH-1:0]  r_ch_pwr;
    logic [VAL_W-1:0] r_rd_data;
    logic             r_wr_err;

    logic             w_wr_fire;
    logic             w_wr_bad;
    logic             w_rd_ch_ok;
    logic [VAL_W-1:0] w_cap_clamped;
    logic [VAL_W-1:0] w_rd_val;

    // Writes are only accepted while the appliance is powered, which also
    // freezes the register file whenever pwr is low.
    assign wr_ready  = pwr;
    assign w_wr_fire = wr_valid && pwr;
    assign w_wr_bad  = (field_e'(wr_field) == FIELD_RSVD) || ({1'b0, wr_ch} >= c_N_CH);
    assign w_rd_ch_ok = ({1'b0, rd_ch} < c_N_CH);

    assign w_cap_clamped = (wr_data > c_CAP_MAX) ? c_CAP_MAX : wr_data;

    // Register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_sp[k]  <= c_SP_RST;
                r_cap[k] <= '0;
            end
            r_ch_pwr <= '0;
        end else if (w_wr_fire && !w_wr_bad) begin
            case (field_e'(wr_field))
                FIELD_SP:  r_sp[wr_ch]     <= wr_data;
                FIELD_CAP: r_cap[wr_ch]    <= w_cap_clamped;
                FIELD_PWR: r_ch_pwr[wr_ch] <= wr_data[0];
                default:   ;
            endcase
        end
    end

    // Error pulse: high for exactly the cycle after an accepted illegal write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_fire && w_wr_bad;
        end
    end

    // Read mux samples the pre-write contents, giving read-before-write
    // behaviour when read and write hit the same address in one cycle.
    always_comb begin
        w_rd_val = '0;
        if (w_rd_ch_ok) begin
            case (field_e'(rd_field))
                FIELD_SP:  w_rd_val = r_sp[rd_ch];
                FIELD_CAP: w_rd_val = r_cap[rd_ch];
                FIELD_PWR: w_rd_val = VAL_W'(r_ch_pwr[rd_ch]);
                default:   w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_val;
        end
    end

    assign rd_data = r_rd_data;
    assign wr_err  = r_wr_err;

    // One compressor controller per compartment
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        fridge_comp_fsm #(
            .VAL_W   (VAL_W),
            .HYST    (HYST),
            .MIN_OFF (MIN_OFF)
        ) u_comp_fsm (
            .clk      (clk),
            .rst_n    (rst_n),
            .pwr      (pwr),
            .ch_pwr   (r_ch_pwr[k]),
            .temp     (temp_sense[k*VAL_W +: VAL_W]),
            .setpoint (r_sp[k]),
            .comp_on  (comp_on[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_fridge_ctrl_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_fridge_ctrl_bank
// Description : Directed self-checking bench for fridge_ctrl_bank with
//               default parameters (N_CH=2, VAL_W=5, HYST=2, MIN_OFF=16,
//               CAP_MAX=20, SP_RST=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fridge_ctrl_bank;

    logic       clk;
    logic       rst_n;
    logic       pwr;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_field;
    logic [0:0] wr_ch;
    logic [4:0] wr_data;
    logic       wr_err;
    logic [1:0] rd_field;
    logic [0:0] rd_ch;
    logic [4:0] rd_data;
    logic [9:0] temp_sense;
    logic [1:0] comp_on;

    int n_checks = 0;
    int n_fail   = 0;

    fridge_ctrl_bank u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwr        (pwr),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_field   (wr_field),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .rd_field   (rd_field),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .temp_sense (temp_sense),
        .comp_on    (comp_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] f, input logic [0:0] ch, input logic [4:0] d);
        wr_valid = 1'b1;
        wr_field = f;
        wr_ch    = ch;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] f, input logic [0:0] ch,
                            input logic [4:0] exp);
        rd_field = f;
        rd_ch    = ch;
        tick();
        check_eq(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int got;
        rst_n      = 1'b0;
        pwr        = 1'b0;
        wr_valid   = 1'b0;
        wr_field   = 2'd0;
        wr_ch      = 1'b0;
        wr_data    = 5'd0;
        rd_field   = 2'd0;
        rd_ch      = 1'b0;
        temp_sense = '0;

        #2;
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_comp_on", 32'(comp_on), 32'd0);
        check_eq("rst_wr_err", 32'(wr_err), 32'd0);
        check_eq("rst_wr_ready_pwr0", 32'(wr_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        pwr   = 1'b1;
        #1;
        check_eq("wr_ready_pwr1", 32'(wr_ready), 32'd1);

        // Setpoint write with simultaneous read of the same address: old value
        rd_field = 2'd0;
        rd_ch    = 1'b1;
        do_write(2'd0, 1'b1, 5'd7);
        check_eq("rbw_sp1_old", 32'(rd_data), 32'd4);
        read_chk("sp1_new", 2'd0, 1'b1, 5'd7);
        read_chk("sp0_reset", 2'd0, 1'b0, 5'd4);

        // Capacity clamp and pass-through
        do_write(2'd1, 1'b0, 5'd31);
        read_chk("cap0_clamp", 2'd1, 1'b0, 5'd20);
        do_write(2'd1, 1'b1, 5'd13);
        read_chk("cap1_pass", 2'd1, 1'b1, 5'd13);

        // Reserved field write: error pulse for one cycle, nothing changes
        do_write(2'd3, 1'b0, 5'd9);
        check_eq("wr_err_pulse", 32'(wr_err), 32'd1);
        tick();
        check_eq("wr_err_clear", 32'(wr_err), 32'd0);
        read_chk("sp0_after_bad", 2'd0, 1'b0, 5'd4);
        read_chk("cap0_after_bad", 2'd1, 1'b0, 5'd20);
        read_chk("sp1_after_bad", 2'd0, 1'b1, 5'd7);
        read_chk("rd_field3", 2'd3, 1'b0, 5'd0);
        read_chk("chpwr0_off", 2'd2, 1'b0, 5'd0);

        // Channel 0 on; temp 6 is not above 4+2 so no cut-in
        temp_sense[4:0] = 5'd6;
        do_write(2'd2, 1'b0, 5'd1);
        read_chk("chpwr0_on", 2'd2, 1'b0, 5'd1);
        for (int i = 0; i < 4; i++) tick();
        check_eq("no_cut_in_at_6", 32'(comp_on), 32'd0);
        temp_sense[4:0] = 5'd7;
        tick();
        check_eq("cut_in_at_7", 32'(comp_on), 32'd1);

        // Cut-out at setpoint, then a 16-cycle lockout ignoring temperature
        temp_sense[4:0] = 5'd4;
        tick();
        check_eq("cut_out_at_4", 32'(comp_on), 32'd0);
        temp_sense[4:0] = 5'd10;
        for (int i = 0; i < 16; i++) tick();
        check_eq("lockout_hold", 32'(comp_on), 32'd0);
        tick();
        check_eq("recool_after_lockout", 32'(comp_on), 32'd1);

        // Raising the setpoint during COOL is used on the following compare;
        // lowering it during lockout must not restart the count.
        do_write(2'd0, 1'b0, 5'd12);
        check_eq("sp_change_same_edge", 32'(comp_on), 32'd1);
        tick();
        check_eq("sp_change_cut_out", 32'(comp_on), 32'd0);
        do_write(2'd0, 1'b0, 5'd4);
        got = 0;
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (comp_on[0]) begin
                got = i;
                break;
            end
        end
        check_eq("relock_len", 32'(got), 32'd17);

        // Master power drop during COOL
        pwr      = 1'b0;
        wr_valid = 1'b1;
        wr_field = 2'd0;
        wr_ch    = 1'b0;
        wr_data  = 5'd20;
        rd_field = 2'd0;
        rd_ch    = 1'b0;
        #1;
        check_eq("wr_ready_pwr_off", 32'(wr_ready), 32'd0);
        tick();
        check_eq("comp_off_pwr_drop", 32'(comp_on), 32'd0);
        check_eq("no_err_pwr_off", 32'(wr_err), 32'd0);
        tick();
        check_eq("sp0_hold_pwr_off", 32'(rd_data), 32'd4);
        wr_valid = 1'b0;
        pwr      = 1'b1;
        read_chk("sp0_after_pwr", 2'd0, 1'b0, 5'd4);
        read_chk("chpwr0_hold", 2'd2, 1'b0, 5'd1);

        // Back to COOL (OFF->IDLE->COOL), then into lockout
        rd_field = 2'd0;
        rd_ch    = 1'b0;
        tick();
        check_eq("recool_after_pwr", 32'(comp_on), 32'd1);
        temp_sense[4:0] = 5'd4;
        tick();
        tick();
        tick();
        check_eq("lockout_again", 32'(comp_on), 32'd0);
        check_eq("rd_before_reset", 32'(rd_data), 32'd4);

        // Reset mid-lockout with a write pending: async clear, write discarded
        wr_valid = 1'b1;
        wr_field = 2'd0;
        wr_ch    = 1'b0;
        wr_data  = 5'd9;
        temp_sense[4:0] = 5'd10;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("async_rst_comp_on", 32'(comp_on), 32'd0);
        check_eq("async_rst_wr_err", 32'(wr_err), 32'd0);
        tick();
        wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        read_chk("sp0_after_rst", 2'd0, 1'b0, 5'd4);
        read_chk("sp1_after_rst", 2'd0, 1'b1, 5'd4);
        read_chk("cap0_after_rst", 2'd1, 1'b0, 5'd0);
        read_chk("chpwr0_after_rst", 2'd2, 1'b0, 5'd0);
        check_eq("comp_off_after_rst", 32'(comp_on), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
